sc_run_ctrl: RTL

Run controller for the single-cycle RISC-V core. It loads a program image into instruction memory over a valid/ready stream, then releases the CPU from reset and clock-enables it. It stops the CPU on a halt instruction (ECALL) or on a watchdog timeout, and reports status and the cycle count. It sits between the bench or host loader and `SingleCycleCPU`, and owns the CPU's reset and enable.

---
 rtl/sc_run_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/sc_run_ctrl.sv
// Run controller for the single-cycle RISC-V core: streams a program image into
// instruction memory, then owns the CPU reset/enable through RUN and HALT.
module sc_run_ctrl #(
    parameter int          ADDR_W     = 8,
    parameter int          IMEM_DEPTH = 256,
    parameter int          MAX_CYCLES = 300,
    parameter logic [31:0] HALT_INSTR = 32'h00000073
) (
    input  logic              clk,
    input  logic              start,
    input  logic              go,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    input  logic [31:0]       cpu_instr,
    output logic              cpu_rst_n,
    output logic              cpu_en,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              ovf,
    output logic              loaded,
    output logic [31:0]       cycle_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [31:0]       WD_LIMIT  = 32'(MAX_CYCLES - 1);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t            state_q, state_d;
    logic              rel_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ld_ready_q, ld_ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              cpu_en_q, cpu_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              ovf_q, ovf_d;
    logic              loaded_q, loaded_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              accept;
    logic [ADDR_W-1:0] beat_addr;

    // Release flop: together with the state registers it forms the two-flop
    // release, so the first state change lands on the second edge after start rises.
    always_ff @(posedge clk or negedge start) begin
        if (!start) rel_q <= 1'b0;
        else        rel_q <= 1'b1;
    end

    assign accept    = ld_valid & ld_ready_q;
    assign beat_addr = (state_q == IDLE) ? '0 : addr_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        ovf_d     = ovf_q;
        loaded_d  = loaded_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    // An IDLE beat begins a fresh image at address 0.
                    we_d     = 1'b1;
                    waddr_d  = beat_addr;
                    wdata_d  = ld_data;
                    loaded_d = 1'b0;
                    ovf_d    = 1'b0;
                    if (ld_last) begin
                        state_d  = IDLE;
                        loaded_d = 1'b1;
                        addr_d   = '0;
                    end else if (beat_addr == LAST_ADDR) begin
                        state_d  = IDLE;
                        loaded_d = 1'b1;
                        ovf_d    = 1'b1;
                        addr_d   = '0;
                    end else begin
                        state_d  = LOAD;
                        addr_d   = beat_addr + ADDR_ONE;
                    end
                end else if (state_q == IDLE && go && loaded_q) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = sat_inc(cnt_q);
                if (cpu_instr == HALT_INSTR) begin
                    state_d = HALT;
                    done_d  = 1'b1;
                end else if (cnt_q == WD_LIMIT) begin
                    state_d   = HALT;
                    timeout_d = 1'b1;
                end
            end
            HALT: begin
                if (go) begin
                    state_d   = IDLE;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        ld_ready_d  = (state_d == IDLE) || (state_d == LOAD);
        busy_d      = (state_d == LOAD) || (state_d == RUN);
        cpu_rst_n_d = (state_d == RUN) || (state_d == HALT);
        cpu_en_d    = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            ld_ready_q  <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            cpu_rst_n_q <= 1'b0;
            cpu_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            ovf_q       <= 1'b0;
            loaded_q    <= 1'b0;
            cnt_q       <= '0;
        end else if (rel_q) begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            ld_ready_q  <= ld_ready_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            cpu_en_q    <= cpu_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            ovf_q       <= ovf_d;
            loaded_q    <= loaded_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ld_ready   = ld_ready_q;
    assign imem_we    = we_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign cpu_rst_n  = cpu_rst_n_q;
    assign cpu_en     = cpu_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign ovf        = ovf_q;
    assign loaded     = loaded_q;
    assign cycle_cnt  = cnt_q;

endmodule
